// File: rtl/parking_slot_manager.sv
// Registered occupancy tracker for a parking area: lowest-free-slot allocation,
// slot release, sensor OR-in, and registered free count / full / empty status.
module parking_slot_manager #(
  parameter  int NUM_SLOTS = 8,
  localparam int IDX_W     = $clog2(NUM_SLOTS),
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 park_req,
  output logic                 park_grant,
  output logic                 park_reject,
  output logic [IDX_W-1:0]     park_slot,
  input  logic                 leave_req,
  input  logic [IDX_W-1:0]     leave_slot,
  output logic                 leave_ack,
  output logic                 leave_err,
  input  logic                 sensor_vld,
  input  logic [NUM_SLOTS-1:0] sensor_mask,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0]     free_count,
  output logic                 full,
  output logic                 empty
);

  logic [NUM_SLOTS-1:0] sm;
  logic [NUM_SLOTS-1:0] leave_bit;
  logic                 leave_hit;
  logic [NUM_SLOTS-1:0] cand;
  logic [NUM_SLOTS-1:0] grant_bit;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_found;
  logic [NUM_SLOTS-1:0] next_occ;
  logic [CNT_W-1:0]     occ_ones;

  // Allocation looks only at the current occupancy and this cycle's sensors,
  // so a slot being released now cannot be handed out in the same cycle.
  always_comb begin
    sm          = sensor_vld ? sensor_mask : '0;
    leave_bit   = '0;
    grant_bit   = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    occ_ones    = '0;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (leave_req && (leave_slot == IDX_W'(i))) begin
        leave_bit[i] = 1'b1;
      end
    end
    leave_hit = |(leave_bit & occupancy);

    cand = ~occupancy & ~sm;
    if (park_req) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cand[i] && !grant_found) begin
          grant_bit[i] = 1'b1;
          grant_idx    = IDX_W'(i);
          grant_found  = 1'b1;
        end
      end
    end

    next_occ = ((occupancy & ~leave_bit) | sm) | grant_bit;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      occ_ones = occ_ones + CNT_W'(next_occ[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy   <= '0;
      free_count  <= CNT_W'(NUM_SLOTS);
      full        <= 1'b0;
      empty       <= 1'b1;
      park_grant  <= 1'b0;
      park_reject <= 1'b0;
      park_slot   <= '0;
      leave_ack   <= 1'b0;
      leave_err   <= 1'b0;
    end else begin
      occupancy   <= next_occ;
      free_count  <= CNT_W'(NUM_SLOTS) - occ_ones;
      full        <= (occ_ones == CNT_W'(NUM_SLOTS));
      empty       <= (occ_ones == '0);
      park_grant  <= park_req && grant_found;
      park_reject <= park_req && !grant_found;
      park_slot   <= grant_found ? grant_idx : '0;
      leave_ack   <= leave_req && leave_hit;
      leave_err   <= leave_req && !leave_hit;
    end
  end

endmodule

// File: tb/tb_parking_slot_manager.sv
// Table-driven, scoreboard-checked bench for parking_slot_manager (8 slots).
module tb_parking_slot_manager;

  localparam int N   = 8;
  localparam int IW  = 3;
  localparam int CW  = 4;

  typedef struct {
    logic          park;
    logic          leave;
    logic [IW-1:0] lslot;
    logic          svld;
    logic [N-1:0]  smask;
    logic          grant;
    logic          reject;
    logic [IW-1:0] pslot;
    logic          ack;
    logic          err;
    logic [N-1:0]  occ;
    logic [CW-1:0] free;
    logic          full;
    logic          empty;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          park_req;
  logic          park_grant;
  logic          park_reject;
  logic [IW-1:0] park_slot;
  logic          leave_req;
  logic [IW-1:0] leave_slot;
  logic          leave_ack;
  logic          leave_err;
  logic          sensor_vld;
  logic [N-1:0]  sensor_mask;
  logic [N-1:0]  occupancy;
  logic [CW-1:0] free_count;
  logic          full;
  logic          empty;

  int   tests = 0;
  int   fails = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  parking_slot_manager #(.NUM_SLOTS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .park_req(park_req), .park_grant(park_grant), .park_reject(park_reject), .park_slot(park_slot),
    .leave_req(leave_req), .leave_slot(leave_slot), .leave_ack(leave_ack), .leave_err(leave_err),
    .sensor_vld(sensor_vld), .sensor_mask(sensor_mask),
    .occupancy(occupancy), .free_count(free_count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic park, logic leave, logic [IW-1:0] lslot, logic svld,
                              logic [N-1:0] smask, logic grant, logic reject, logic [IW-1:0] pslot,
                              logic ack, logic err, logic [N-1:0] occ, logic [CW-1:0] free,
                              logic fl, logic em);
    vec_t v;
    v.park = park; v.leave = leave; v.lslot = lslot; v.svld = svld; v.smask = smask;
    v.grant = grant; v.reject = reject; v.pslot = pslot; v.ack = ack; v.err = err;
    v.occ = occ; v.free = free; v.full = fl; v.empty = em;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, " occupancy"}, 32'(occupancy), 32'h00);
    cmp({tag, " free_count"}, 32'(free_count), 32'd8);
    cmp({tag, " empty"}, 32'(empty), 32'd1);
    cmp({tag, " full"}, 32'(full), 32'd0);
    cmp({tag, " park_grant"}, 32'(park_grant), 32'd0);
    cmp({tag, " park_reject"}, 32'(park_reject), 32'd0);
    cmp({tag, " park_slot"}, 32'(park_slot), 32'd0);
    cmp({tag, " leave_ack"}, 32'(leave_ack), 32'd0);
    cmp({tag, " leave_err"}, 32'(leave_err), 32'd0);
  endtask

  task automatic checkOutput();
    vec_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard: no expected entry at %0t", $time);
      return;
    end
    tests--;
    e = exp_q.pop_front();
    cmp("park_grant", 32'(park_grant), 32'(e.grant));
    cmp("park_reject", 32'(park_reject), 32'(e.reject));
    cmp("park_slot", 32'(park_slot), 32'(e.pslot));
    cmp("leave_ack", 32'(leave_ack), 32'(e.ack));
    cmp("leave_err", 32'(leave_err), 32'(e.err));
    cmp("occupancy", 32'(occupancy), 32'(e.occ));
    cmp("free_count", 32'(free_count), 32'(e.free));
    cmp("full", 32'(full), 32'(e.full));
    cmp("empty", 32'(empty), 32'(e.empty));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    park_req    = v.park;
    leave_req   = v.leave;
    leave_slot  = v.lslot;
    sensor_vld  = v.svld;
    sensor_mask = v.smask;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [8:0] run_occ;

    // Vectors continuing from the full lot left by the park burst.
    tbl.push_back(mk(1, 1, 3, 0, 8'h00, 0, 1, 0, 1, 0, 8'hF7, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h08, 0, 0, 0, 0, 0, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(0, 1, 5, 1, 8'h20, 0, 0, 0, 1, 0, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(0, 1, 7, 0, 8'h00, 0, 0, 0, 1, 0, 8'h7F, 1, 0, 0));
    tbl.push_back(mk(0, 1, 7, 0, 8'h00, 0, 0, 0, 0, 1, 8'h7F, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 7, 0, 0, 8'hFF, 0, 1, 0));
    run_occ = 9'h0FF;
    for (int s = 7; s >= 1; s--) begin
      run_occ = run_occ >> 1;
      tbl.push_back(mk(0, 1, IW'(s), 0, 8'h00, 0, 0, 0, 1, 0, run_occ[7:0], CW'(8 - s), 0, 0));
    end
    tbl.push_back(mk(0, 1, 5, 0, 8'h00, 0, 0, 0, 0, 1, 8'h01, 7, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 8'h03, 1, 0, 2, 0, 0, 8'h07, 5, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 1, 0, 3, 1, 0, 8'h0E, 5, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h0F, 4, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 4, 0, 0, 8'h1F, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h1F, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 8'hE0, 0, 1, 0, 0, 0, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'hFE, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h00, 0, 0, 0, 1, 0, 8'hFC, 2, 0, 0));

    rst_n = 1'b0;
    park_req = 1'b0; leave_req = 1'b0; leave_slot = '0;
    sensor_vld = 1'b0; sensor_mask = '0;
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the lot one slot per cycle, then one request too many.
    for (int i = 0; i < 8; i++) begin
      run_occ = (9'h1 << (i + 1)) - 9'h1;
      applyStimulus(mk(1, 0, 0, 0, 8'h00, 1, 0, IW'(i), 0, 0, run_occ[7:0], CW'(7 - i), i == 7, 0));
    end
    applyStimulus(mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hFF, 0, 1, 0));

    foreach (tbl[k]) applyStimulus(tbl[k]);

    // Reset lands while a grant pulse is visible and another request is pending.
    applyStimulus(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'hFD, 1, 0, 0));
    @(negedge clk);
    park_req = 1'b1;
    #2 rst_n = 1'b0;
    #1 checkReset("async reset");
    exp_q.delete();
    @(posedge clk);
    #1 checkReset("held reset");
    @(negedge clk);
    park_req = 1'b0;
    rst_n = 1'b1;
    applyStimulus(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h01, 7, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h01, 7, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
